alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready request port and a
// valid/ready result port. Single-cycle ops (ADD, SUB, AND, OR, SLT and the
// two reserved codes) complete with latency 1. MUL is a sequential
// shift-add multiplier that takes WIDTH cycles and blocks new requests
// while it runs.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// that port. The producer holds valid and data stable until the transfer.
// The consumer may change ready freely. Request inputs are sampled only on
// an accepting edge. The held result stays stable until it is consumed.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-high reset
//   SrcA, SrcB - operands (WIDTH bits)
//   ALUControl - operation select:
//                010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT, 011 MUL,
//                100/101 -> 0
//   in_valid   - request valid
//   in_ready   - request may be accepted
//   ALUResult  - registered result
//   Zero       - registered ALUResult == 0
//   Carry      - carry-out (ADD) / no-borrow (SUB), else 0
//   Overflow   - signed overflow (ADD/SUB), else 0
//   out_valid  - result valid
//   out_ready  - consumer accepts result
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   counter;
    logic [WIDTH-1:0]  mul_a;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]  mul_b;    // multiplier, shifted right each step
    logic [WIDTH-1:0]  acc;      // partial product (low WIDTH bits)

    logic              accept;
    logic              consume;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [WIDTH-1:0]  acc_next;
    logic              last_step;

    // Accept only from IDLE and only when the result slot is free or is
    // being drained on the same edge.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // One extra bit carries the ADD carry-out / SUB no-borrow.
    assign sum_ext  = {1'b0, SrcA} + {1'b0, SrcB};
    assign diff_ext = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                // Same-sign operands producing an opposite-sign sum.
                alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                // Opposite-sign operands with the difference taking B's sign.
                alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND: alu_res = SrcA & SrcB;
            OP_OR:  alu_res = SrcA | SrcB;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_res = '0;  // MUL handled by the FSM; 100/101 give 0
        endcase
    end

    assign acc_next  = acc + (mul_b[0] ? mul_a : '0);
    assign last_step = (counter == CNTW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ALUControl == OP_MUL) begin
                            state     <= MUL;
                            counter   <= '0;
                            mul_a     <= SrcA;
                            mul_b     <= SrcB;
                            acc       <= '0;
                            // Any held result is being consumed on this edge.
                            out_valid <= 1'b0;
                        end else begin
                            ALUResult <= alu_res;
                            Zero      <= (alu_res == '0);
                            Carry     <= alu_c;
                            Overflow  <= alu_v;
                            out_valid <= 1'b1;
                        end
                    end else if (consume) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    // out_valid is 0 for the whole MUL, so nothing to consume.
                    acc     <= acc_next;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    counter <= counter + CNTW'(1);
                    if (last_step) begin
                        ALUResult <= acc_next;
                        Zero      <= (acc_next == '0);
                        Carry     <= 1'b0;
                        Overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        counter   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
